// File: rtl/alu_execute_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_execute_stage_pkg
//   Shared definitions for the LEGv8 execute stage: datapath width default,
//   4-bit ALU control codes, ALUOp encodings and the R-type opcode values
//   found in instruction[31:21].
// -----------------------------------------------------------------------------
package alu_execute_stage_pkg;

    localparam int DEFAULT_WIDTH = 64;

    // ALU control codes driven to the ALU core.
    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_ctrl_e;

    // {ALUOp1, ALUOp0} encodings from the main control unit; any value with
    // ALUOp1 set selects R-type decode of the opcode field.
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_CBZ = 2'b01;

    // R-type opcodes, instruction[31:21].
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

endpackage : alu_execute_stage_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Combinational WIDTH-bit ALU with zero detect. Arithmetic wraps modulo
//   2^WIDTH; there are no carry/overflow flags. Unknown codes yield 0.
// Ports:
//   operation_code  in   4       ALU control code
//   operand_a       in   WIDTH   first operand
//   operand_b       in   WIDTH   second operand
//   result          out  WIDTH   ALU result
//   zero            out  1       result == 0
// -----------------------------------------------------------------------------
module alu_core
    import alu_execute_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [3:0]       operation_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (operation_code)
            ALU_AND:   result = operand_a & operand_b;
            ALU_OR:    result = operand_a | operand_b;
            ALU_ADD:   result = operand_a + operand_b;
            ALU_SUB:   result = operand_a - operand_b;
            ALU_PASSB: result = operand_b;
            ALU_NOR:   result = ~(operand_a | operand_b);
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule : alu_core

// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
//   Combinational ALU control: maps the control unit's ALUOp bits and the
//   instruction opcode field onto a 4-bit ALU operation.
// Ports:
//   alu_op            in   2   {ALUOp1, ALUOp0}
//   instruction_part  in  11   instruction[31:21]
//   operation_code    out  4   decoded ALU operation
// -----------------------------------------------------------------------------
module alu_ctrl_decode
    import alu_execute_stage_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [10:0] instruction_part,
    output alu_ctrl_e   operation_code
);

    always_comb begin
        // NOTE: assigning a default before any branch keeps this purely
        // combinational; a path that leaves it unassigned would infer a latch.
        operation_code = ALU_ADD;
        if (alu_op[1]) begin
            // ALUOp0 is a don't-care once ALUOp1 selects R-type decode.
            case (instruction_part)
                OPC_ADD: operation_code = ALU_ADD;
                OPC_SUB: operation_code = ALU_SUB;
                OPC_AND: operation_code = ALU_AND;
                OPC_ORR: operation_code = ALU_OR;
                default: operation_code = ALU_ADD;
            endcase
        end else if (alu_op == ALUOP_CBZ) begin
            operation_code = ALU_PASSB;
        end
        // ALUOP_MEM keeps the default add for address generation.
    end

endmodule : alu_ctrl_decode

// File: rtl/alu_execute_stage.sv
// -----------------------------------------------------------------------------
// alu_execute_stage
//   Execute stage of a single-cycle LEGv8 datapath. Decodes the ALU
//   operation, runs the ALU, forms PC+4 and the branch target, selects the
//   next PC, and captures everything in one output register (latency 1).
//   When in_valid is low the data outputs hold and out_valid drops.
// Ports:
//   clock             in   1      rising-edge clock
//   reset             in   1      asynchronous active-low, clears outputs
//   in_valid          in   1      inputs valid this edge
//   alu_op            in   2      {ALUOp1, ALUOp0}
//   instruction_part  in   11     instruction[31:21]
//   operand_a         in   WIDTH  register data 1
//   operand_b         in   WIDTH  second operand (reg or immediate)
//   pc                in   WIDTH  current PC
//   branch_offset     in   WIDTH  sign-extended word offset
//   branch            in   1      branch instruction flag
//   out_valid         out  1      registered in_valid
//   operation_code    out  4      registered ALU operation
//   result            out  WIDTH  registered ALU result
//   zero              out  1      registered result == 0
//   pc_plus4          out  WIDTH  registered pc + 4
//   branch_target     out  WIDTH  registered pc + (branch_offset << 2)
//   next_pc           out  WIDTH  registered selected next PC
// -----------------------------------------------------------------------------
module alu_execute_stage
    import alu_execute_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      instruction_part,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             branch,
    output logic             out_valid,
    output logic [3:0]       operation_code,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] next_pc
);

    alu_ctrl_e        op_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic [WIDTH-1:0] pc_plus4_d;
    logic [WIDTH-1:0] branch_target_d;
    logic [WIDTH-1:0] next_pc_d;

    alu_ctrl_decode u_decode (
        .alu_op           (alu_op),
        .instruction_part (instruction_part),
        .operation_code   (op_d)
    );

    alu_core #(.WIDTH(WIDTH)) u_core (
        .operation_code (op_d),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .result         (result_d),
        .zero           (zero_d)
    );

    // Word offset shifted to a byte offset; the two MSBs fall off the top.
    logic [1:0] unused_offset_msbs;
    assign unused_offset_msbs = branch_offset[WIDTH-1:WIDTH-2];

    assign pc_plus4_d      = pc + WIDTH'(4);
    assign branch_target_d = pc + {branch_offset[WIDTH-3:0], 2'b00};
    // Branch decision uses this cycle's ALU zero, not the registered one.
    assign next_pc_d       = (branch && zero_d) ? branch_target_d : pc_plus4_d;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            operation_code <= '0;
            result         <= '0;
            zero           <= 1'b0;
            pc_plus4       <= '0;
            branch_target  <= '0;
            next_pc        <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                operation_code <= op_d;
                result         <= result_d;
                zero           <= zero_d;
                pc_plus4       <= pc_plus4_d;
                branch_target  <= branch_target_d;
                next_pc        <= next_pc_d;
            end
        end
    end

endmodule : alu_execute_stage

// File: tb/tb_alu_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_execute_stage
//   Self-checking bench: directed cases plus randomized operations compared
//   against a behavioural model of the execute stage.
// -----------------------------------------------------------------------------
module tb_alu_execute_stage;

    localparam int W = 64;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [1:0]   alu_op;
    logic [10:0]  instruction_part;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [W-1:0] pc;
    logic [W-1:0] branch_offset;
    logic         branch;
    logic         out_valid;
    logic [3:0]   operation_code;
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] branch_target;
    logic [W-1:0] next_pc;

    alu_execute_stage #(.WIDTH(W)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .alu_op           (alu_op),
        .instruction_part (instruction_part),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .pc               (pc),
        .branch_offset    (branch_offset),
        .branch           (branch),
        .out_valid        (out_valid),
        .operation_code   (operation_code),
        .result           (result),
        .zero             (zero),
        .pc_plus4         (pc_plus4),
        .branch_target    (branch_target),
        .next_pc          (next_pc)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam logic [10:0] R_ADD = 11'b10001011000;
    localparam logic [10:0] R_SUB = 11'b11001011000;
    localparam logic [10:0] R_AND = 11'b10001010000;
    localparam logic [10:0] R_ORR = 11'b10101010000;

    logic         m_valid;
    logic [3:0]   m_code;
    logic [W-1:0] m_result;
    logic         m_zero;
    logic [W-1:0] m_pc4;
    logic [W-1:0] m_bt;
    logic [W-1:0] m_npc;

    function automatic logic [3:0] model_code(logic [1:0] aop, logic [10:0] ip);
        if (aop == 2'd0) return 4'd2;
        if (aop == 2'd1) return 4'd7;
        if (ip == R_SUB) return 4'd6;
        if (ip == R_AND) return 4'd0;
        if (ip == R_ORR) return 4'd1;
        return 4'd2;
    endfunction

    function automatic logic [W-1:0] model_alu(logic [3:0] code, logic [W-1:0] a, logic [W-1:0] b);
        case (code)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return b;
            4'd12:   return ~(a | b);
            default: return '0;
        endcase
    endfunction

    task automatic model_clear();
        m_valid = 0; m_code = 0; m_result = 0; m_zero = 0;
        m_pc4 = 0; m_bt = 0; m_npc = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, W'(out_valid), W'(m_valid));
        check({tag, ".op"},        W'(operation_code), W'(m_code));
        check({tag, ".result"},    result, m_result);
        check({tag, ".zero"},      W'(zero), W'(m_zero));
        check({tag, ".pc_plus4"},  pc_plus4, m_pc4);
        check({tag, ".target"},    branch_target, m_bt);
        check({tag, ".next_pc"},   next_pc, m_npc);
    endtask

    // Drive one cycle of inputs, advance the model, check one edge later.
    task automatic step(input string tag, input logic v, input logic [1:0] aop,
                        input logic [10:0] ip, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] p,
                        input logic [W-1:0] off, input logic br);
        @(negedge clock);
        in_valid = v; alu_op = aop; instruction_part = ip;
        operand_a = a; operand_b = b; pc = p; branch_offset = off; branch = br;
        @(posedge clock);
        m_valid = v;
        if (v) begin
            m_code   = model_code(aop, ip);
            m_result = model_alu(m_code, a, b);
            m_zero   = (m_result == 0);
            m_pc4    = p + 64'd4;
            m_bt     = p + off * 64'd4;
            m_npc    = (br && m_zero) ? m_bt : m_pc4;
        end
        #1;
        check_all(tag);
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reset asserted between clock edges while an operation is being driven.
    task automatic mid_reset(input string tag);
        @(negedge clock);
        in_valid = 1; alu_op = 2'b10; instruction_part = R_ADD;
        operand_a = rnd64(); operand_b = rnd64(); pc = rnd64();
        branch_offset = rnd64(); branch = 1;
        #2 reset = 0;
        #1;
        model_clear();
        check_all({tag, ".immediate"});
        @(posedge clock);
        #1;
        check_all({tag, ".held"});
        @(negedge clock);
        reset = 1;
        in_valid = 0;
    endtask

    logic [10:0] opcodes [4] = '{R_ADD, R_SUB, R_AND, R_ORR};
    logic [W-1:0] rtype_exp [4] = '{64'h12C, 64'hB4, 64'h30, 64'hFC};

    initial begin
        reset = 0; in_valid = 0; alu_op = 0; instruction_part = 0;
        operand_a = 0; operand_b = 0; pc = 0; branch_offset = 0; branch = 0;
        model_clear();
        #12;
        check_all("reset");
        @(negedge clock);
        reset = 1;

        // Some traffic, then reset mid-stream.
        for (int i = 0; i < 4; i++)
            step("pre", 1'b1, 2'b10, opcodes[i], rnd64(), rnd64(), rnd64(), rnd64(), 1'b0);
        mid_reset("midrst");

        // First operation after release.
        step("add5_7", 1'b1, 2'b00, 11'h7FF, 64'd5, 64'd7, 64'h40, 64'd1, 1'b0);
        check("tp.add5_7.result", result, 64'd12);
        check("tp.add5_7.zero", W'(zero), W'(0));
        check("tp.add5_7.op", W'(operation_code), W'(4'b0010));

        // R-type decode.
        for (int i = 0; i < 4; i++) begin
            step("rtype", 1'b1, 2'b10, opcodes[i], 64'hF0, 64'h3C, 64'h200, 64'd0, 1'b0);
            check($sformatf("tp.rtype%0d.result", i), result, rtype_exp[i]);
        end
        check("tp.sub.op", W'(operation_code), W'(4'b0001)); // last one was ORR
        step("sub_op", 1'b1, 2'b11, R_SUB, 64'hF0, 64'h3C, 64'h0, 64'd0, 1'b0);
        check("tp.sub.code", W'(operation_code), W'(4'b0110));

        // Wrap and zero.
        step("sub_eq", 1'b1, 2'b10, R_SUB, 64'h1234, 64'h1234, 64'h0, 64'd0, 1'b0);
        check("tp.sub_eq.zero", W'(zero), W'(1));
        step("add_wrap", 1'b1, 2'b10, R_ADD, '1, 64'd1, 64'h0, 64'd0, 1'b0);
        check("tp.add_wrap.result", result, 64'd0);
        check("tp.add_wrap.zero", W'(zero), W'(1));

        // CBZ taken / not taken.
        step("cbz_t", 1'b1, 2'b01, 11'd0, rnd64(), 64'd0, 64'h100, 64'd3, 1'b1);
        check("tp.cbz_t.target", branch_target, 64'h10C);
        check("tp.cbz_t.next_pc", next_pc, 64'h10C);
        step("cbz_n", 1'b1, 2'b01, 11'd0, rnd64(), 64'd9, 64'h100, 64'd3, 1'b1);
        check("tp.cbz_n.zero", W'(zero), W'(0));
        check("tp.cbz_n.next_pc", next_pc, 64'h104);

        // Negative offset, then hold with in_valid low.
        step("negoff", 1'b1, 2'b01, 11'd0, 64'd0, 64'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        check("tp.negoff.target", branch_target, 64'hF8);
        step("hold", 1'b0, 2'b10, R_ORR, 64'h55, 64'hAA, 64'h9000, 64'd77, 1'b0);
        check("tp.hold.valid", W'(out_valid), W'(0));
        check("tp.hold.target", branch_target, 64'hF8);
        check("tp.hold.next_pc", next_pc, 64'hF8);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a, b, off;
            logic [10:0]  ip;
            int sel;
            a   = rnd64();
            sel = int'($urandom_range(0, 7));
            b   = (sel == 0) ? a : (sel == 1) ? 64'd0 : rnd64();
            ip  = ($urandom_range(0, 3) == 0) ? 11'($urandom) : opcodes[$urandom_range(0, 3)];
            off = ($urandom_range(0, 1) == 0) ? W'($signed(8'($urandom))) : rnd64();
            step("rand", ($urandom_range(0, 4) != 0), 2'($urandom), ip, a, b,
                 rnd64(), off, 1'($urandom));
        end

        mid_reset("endrst");
        step("post", 1'b0, 2'b00, 11'd0, 64'd1, 64'd2, 64'd3, 64'd4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule : tb_alu_execute_stage

// File: doc/alu_execute_stage.md
# alu_execute_stage

Execute stage of the single-cycle LEGv8-style ARM datapath: decodes the ALU operation from the control unit's ALUOp bits and the instruction opcode field, performs the 64-bit ALU operation with zero detection, and computes PC+4, the branch target and the selected next PC. All results are captured in an output register, one cycle after the inputs. It sits between register-bank/sign-extend and data-memory/PC logic.

## Interface
Parameters:
- WIDTH, 64, datapath width in bits.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all outputs.
- in_valid  in  1  inputs valid; sampled at the clock edge.
- alu_op  in  2  {ALUOp1, ALUOp0} from the control unit.
- instruction_part  in  11  instruction[31:21].
- operand_a  in  WIDTH  register data 1.
- operand_b  in  WIDTH  second operand (already muxed reg/immediate).
- pc  in  WIDTH  current PC.
- branch_offset  in  WIDTH  sign-extended word offset.
- branch  in  1  branch instruction flag.
- out_valid  out  1  registered in_valid.
- operation_code  out  4  registered decoded ALU operation.
- result  out  WIDTH  registered ALU result.
- zero  out  1  registered (result == 0).
- pc_plus4  out  WIDTH  registered pc + 4.
- branch_target  out  WIDTH  registered pc + (branch_offset << 2).
- next_pc  out  WIDTH  registered (branch & zero) ? branch_target : pc_plus4.

## Operation
ALU control decode (combinational):
- alu_op = 00 -> 0010 (add, for load/store address).
- alu_op = 01 -> 0111 (pass operand_b, for CBZ).
- alu_op = 1x -> decode instruction_part:
  - 10001011000 (ADD) -> 0010.
  - 11001011000 (SUB) -> 0110.
  - 10001010000 (AND) -> 0000.
  - 10101010000 (ORR) -> 0001.
  - Any other value -> 0010 (add).

ALU operations:
- 0000: a & b.
- 0001: a | b.
- 0010: a + b.
- 0110: a - b.
- 0111: b.
- 1100: ~(a | b).
- Any other code: result 0.

Arithmetic and flags:
- All arithmetic is modulo 2^WIDTH.
- No carry or overflow outputs.
- zero = 1 if and only if result == 0, independent of the operation.

Adders:
- pc_plus4 = pc + 4, wrapping.
- branch_target = pc + {branch_offset[WIDTH-3:0], 2'b00}. The top two offset bits are discarded, and the sum wraps.
- next_pc is selected using the zero value of the same cycle's ALU result.

## Timing
- Combinational decode, ALU and adders feed a single output register. Latency is 1 cycle, throughput is 1 operation per cycle, and there is no backpressure.
- On a rising clock edge with in_valid = 1, all outputs load the new values and out_valid becomes 1.
- On a rising clock edge with in_valid = 0, out_valid becomes 0 and the data outputs hold their previous values.
- When reset is low, all outputs are 0 immediately, regardless of the clock, and stay 0 while it is held.
- The first capture happens on the first rising edge after reset is released.
- Reset asserted during an operation discards the captured result.

## Structure
- Shared package holds:
  - ALU opcode constants: AND 0000, OR 0001, ADD 0010, SUB 0110, PASSB 0111, NOR 1100.
  - The R-type opcode constants (ADD, SUB, AND, ORR).
  - The WIDTH default.
- Natural sub-modules:
  - alu_ctrl_decode: combinational ALUOp/opcode decode.
  - alu_core: combinational ALU with zero detect.
- The stage module instantiates both sub-modules plus the two adders and the output register.

## Test plan
- Reset: drive reset low mid-stream -> all outputs 0 at once. After release, alu_op = 00, a = 5, b = 7, in_valid = 1 -> next cycle result = 12, zero = 0, operation_code = 0010.
- R-type decode: alu_op = 10, a = 0xF0, b = 0x3C:
  - ADD -> 0x12C.
  - SUB -> 0xB4 (code 0110).
  - AND -> 0x30.
  - ORR -> 0xFC.
- Wrap and zero: SUB with a = b = 0x1234 -> result 0, zero = 1. ADD with a = 0xFFFF_FFFF_FFFF_FFFF, b = 1 -> result 0, zero = 1.
- CBZ, branch taken: alu_op = 01, b = 0, branch = 1, pc = 0x100, offset = 3 -> branch_target 0x10C, next_pc 0x10C.
- CBZ, not taken: same as above with b = 9 -> zero = 0, next_pc = 0x104.
- Negative offset and hold: offset = 0xFFFF_FFFF_FFFF_FFFE (-2), pc = 0x100 -> branch_target 0xF8. Then in_valid = 0 with different inputs -> out_valid = 0 and the data outputs unchanged.
